// File: rtl/register_file.sv
// register_file: 32-entry GPR file with write-first bypass, debug port and saturating commit counter
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wa,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [ADDR_WIDTH-1:0] ra1,
    input  logic [ADDR_WIDTH-1:0] ra2,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2,
    input  logic [ADDR_WIDTH-1:0] dbg_ra,
    output logic [DATA_WIDTH-1:0] dbg_rd,
    output logic [CNT_WIDTH-1:0]  commit_cnt
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  commit;
    logic                  hit1;
    logic                  hit2;

    assign commit = we && (wa != '0);

    // Storage: register 0 is never written, so it stays at its reset value of 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit) begin
            regs[wa] <= wd;
        end
    end

    // Commit counter holds at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) commit_cnt <= '0;
        else if (commit && !(&commit_cnt)) commit_cnt <= commit_cnt + CNT_WIDTH'(1);
    end

    // Read ports: bypass the in-flight write, but never while reset holds the file at 0
    always_comb begin
        hit1   = rst_n && commit && (wa == ra1);
        hit2   = rst_n && commit && (wa == ra2);
        rd1    = (ra1 == '0) ? '0 : hit1 ? wd : regs[ra1];
        rd2    = (ra2 == '0) ? '0 : hit2 ? wd : regs[ra2];
        dbg_rd = regs[dbg_ra];
    end

endmodule
